// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between completion producers and the regfile write-back arbiter.
// The master side drives requests; the slave side is the arbiter with its regfile write ports.
interface rf_wb_arbiter_if #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RF_SIZE = 32,
  parameter int unsigned XLEN    = 64
);
  localparam int unsigned IDXW = $clog2(RF_SIZE);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][IDXW-1:0]      req_idx;
  logic [NUM_REQ-1:0][XLEN-1:0]      req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic [WIDTH-1:0]                  wr_en;
  logic [WIDTH-1:0][IDXW-1:0]        wr_idx;
  logic [WIDTH-1:0][XLEN-1:0]        wr_data;

  modport master (
    output req_valid, req_idx, req_data,
    input  req_ready, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  req_valid, req_idx, req_data,
    output req_ready, wr_en, wr_idx, wr_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: grants up to WIDTH of NUM_REQ results per cycle, one per index.
// Optional macro RF_WB_ZERO_DROP_EN: index-0 results are acknowledged and discarded.
module rf_wb_arbiter #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RF_SIZE = 32,
  parameter int unsigned XLEN    = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  rf_wb_arbiter_if.slave bus_io
);
  localparam int unsigned IDXW = $clog2(RF_SIZE);
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef RF_WB_ZERO_DROP_EN
  localparam bit ZeroDrop = 1'b1;
`else
  localparam bit ZeroDrop = 1'b0;
`endif

  logic [PtrW-1:0]             rr_q, rr_d;
  logic [WIDTH-1:0]            wr_en_q, wr_en_d;
  logic [WIDTH-1:0][IDXW-1:0]  wr_idx_q, wr_idx_d;
  logic [WIDTH-1:0][XLEN-1:0]  wr_data_q, wr_data_d;
  logic [NUM_REQ-1:0]          grant;

  always_comb begin
    int unsigned sel;
    int unsigned used;
    int unsigned last;
    int unsigned nxt;
    logic        any;
    logic        conflict;
    sel       = 0;
    used      = 0;
    last      = 0;
    nxt       = 0;
    any       = 1'b0;
    conflict  = 1'b0;
    grant     = '0;
    wr_en_d   = '0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    rr_d      = rr_q;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      sel = 32'(rr_q) + j;
      if (sel >= NUM_REQ) sel = sel - NUM_REQ;
      // Only ports already filled this cycle take part in the same-index check
      conflict = 1'b0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (wr_en_d[k] && (wr_idx_d[k] == bus_io.req_idx[sel])) conflict = 1'b1;
      end
      if (bus_io.req_valid[sel]) begin
        if (ZeroDrop && (bus_io.req_idx[sel] == '0)) begin
          grant[sel] = 1'b1;
          any        = 1'b1;
          last       = sel;
        end else if ((used < WIDTH) && !conflict) begin
          grant[sel]      = 1'b1;
          wr_en_d[used]   = 1'b1;
          wr_idx_d[used]  = bus_io.req_idx[sel];
          wr_data_d[used] = bus_io.req_data[sel];
          used            = used + 1;
          any             = 1'b1;
          last            = sel;
        end
      end
    end
    if (any) begin
      nxt = last + 1;
      if (nxt >= NUM_REQ) nxt = 0;
      rr_d = PtrW'(nxt);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= '0;
      wr_en_q   <= '0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Grants are suppressed while reset is held so no requester sees a phantom transfer
  assign bus_io.req_ready = reset_n ? grant : '0;
  assign bus_io.wr_en     = wr_en_q;
  assign bus_io.wr_idx    = wr_idx_q;
  assign bus_io.wr_data   = wr_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a random run against a model,
// with expected regfile writes queued per cycle and compared one cycle later.
module tb_rf_wb_arbiter;
  localparam int unsigned W  = 2;
  localparam int unsigned NR = 4;

`ifdef RF_WB_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  typedef struct {
    logic [1:0]       en;
    logic [1:0][4:0]  idx;
    logic [1:0][63:0] data;
  } wr_exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]       v;
  logic [3:0][4:0]  ix;
  logic [3:0][63:0] dt;
  logic [31:0]      salt = 32'h0;
  wr_exp_t          sb_q[$];
  wr_exp_t          mon_e;

  always #5 clock = ~clock;

  rf_wb_arbiter_if #(.WIDTH(W), .NUM_REQ(NR), .RF_SIZE(32), .XLEN(64)) bus ();

  rf_wb_arbiter #(.WIDTH(W), .NUM_REQ(NR), .RF_SIZE(32), .XLEN(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus_io  (bus.slave)
  );

  // Scoreboard: registered outputs after each edge must match the grants expected a cycle earlier
  always begin
    @(posedge clock);
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.wr_en !== mon_e.en) begin
        errors++;
        $display("FAIL wr_en: got %b expected %b at %0t", bus.wr_en, mon_e.en, $time);
      end
      checks++;
      if (bus.wr_idx !== mon_e.idx) begin
        errors++;
        $display("FAIL wr_idx: got %h expected %h at %0t", bus.wr_idx, mon_e.idx, $time);
      end
      checks++;
      if (bus.wr_data !== mon_e.data) begin
        errors++;
        $display("FAIL wr_data: got %h expected %h at %0t", bus.wr_data, mon_e.data, $time);
      end
    end
  end

  task automatic set_req(input logic [3:0] valid, input int i0, input int i1, input int i2,
                         input int i3);
    v     = valid;
    ix[0] = 5'(i0);
    ix[1] = 5'(i1);
    ix[2] = 5'(i2);
    ix[3] = 5'(i3);
    for (int i = 0; i < 4; i++) dt[i] = {salt, 16'(i), 11'h0, ix[i]};
    bus.req_valid = v;
    bus.req_idx   = ix;
    bus.req_data  = dt;
  endtask

  task automatic push_exp(input int s0, input int s1);
    wr_exp_t e;
    e.en   = '0;
    e.idx  = '0;
    e.data = '0;
    if (s0 >= 0) begin
      e.en[0] = 1'b1; e.idx[0] = ix[s0]; e.data[0] = dt[s0];
    end
    if (s1 >= 0) begin
      e.en[1] = 1'b1; e.idx[1] = ix[s1]; e.data[1] = dt[s1];
    end
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    salt = 32'h1;
    set_req(4'b1111, 1, 2, 3, 4);
    #12;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if (bus.wr_en !== 2'b00 || bus.wr_idx !== '0 || bus.wr_data !== '0) begin
      errors++; $display("FAIL reset_wr: got en=%b idx=%h expected zero", bus.wr_en, bus.wr_idx);
    end
    set_req(4'b0000, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_full_load();
    salt = 32'h2;
    set_req(4'b1111, 1, 2, 3, 4);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0011) begin
      errors++; $display("FAIL full_c0_ready: got %b expected 0011", bus.req_ready);
    end
    push_exp(0, 1);
    @(posedge clock); #1;
    set_req(4'b1100, 1, 2, 3, 4);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b1100) begin
      errors++; $display("FAIL full_c1_ready: got %b expected 1100", bus.req_ready);
    end
    push_exp(2, 3);
    @(posedge clock); #1;
  endtask

  task automatic test_conflict();
    salt = 32'h3;
    set_req(4'b0111, 5, 5, 7, 0);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0101) begin
      errors++; $display("FAIL conflict_ready: got %b expected 0101", bus.req_ready);
    end
    push_exp(0, 2);
    @(posedge clock); #1;
    set_req(4'b0010, 5, 5, 7, 0);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL conflict_loser_ready: got %b expected 0010", bus.req_ready);
    end
    push_exp(1, -1);
    @(posedge clock); #1;
  endtask

  task automatic test_wrap();
    salt = 32'h4;
    set_req(4'b0100, 0, 0, 6, 0);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL wrap_pre_ready: got %b expected 0100", bus.req_ready);
    end
    push_exp(2, -1);
    @(posedge clock); #1;
    set_req(4'b1000, 0, 0, 0, 9);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_ready: got %b expected 1000", bus.req_ready);
    end
    push_exp(3, -1);
    @(posedge clock); #1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      set_req(4'b0000, 0, 0, 0, 0);
      @(negedge clock);
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL idle_ready: got %b expected 0000 cycle %0d", bus.req_ready, c);
      end
      push_exp(-1, -1);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_zero_index();
    salt = 32'h5;
    set_req(4'b0111, 0, 3, 4, 0);
    @(negedge clock);
    checks++;
    if (ZD) begin
      if (bus.req_ready !== 4'b0111) begin
        errors++; $display("FAIL zero_ready: got %b expected 0111", bus.req_ready);
      end
      push_exp(1, 2);
    end else begin
      if (bus.req_ready !== 4'b0011) begin
        errors++; $display("FAIL zero_ready: got %b expected 0011", bus.req_ready);
      end
      push_exp(0, 1);
    end
    @(posedge clock); #1;
    set_req(ZD ? 4'b0000 : 4'b0100, 0, 3, 4, 0);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== (ZD ? 4'b0000 : 4'b0100)) begin
      errors++; $display("FAIL zero_drain_ready: got %b expected %b", bus.req_ready,
                         ZD ? 4'b0000 : 4'b0100);
    end
    if (ZD) push_exp(-1, -1);
    else    push_exp(2, -1);
    @(posedge clock); #1;
  endtask

  // Pointer is 3 on entry; reset must bring it back to 0 and cut the write in flight
  task automatic test_reset_mid();
    salt = 32'h6;
    set_req(4'b1111, 1, 2, 3, 4);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b1001) begin
      errors++; $display("FAIL mid_pre_ready: got %b expected 1001", bus.req_ready);
    end
    push_exp(3, 0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_en !== 2'b00 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: got wr_en=%b ready=%b expected 00/0000",
                         bus.wr_en, bus.req_ready);
    end
    sb_q.delete();
    @(posedge clock); #4;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0011) begin
      errors++; $display("FAIL mid_release_ready: got %b expected 0011", bus.req_ready);
    end
    push_exp(0, 1);
    @(posedge clock); #1;
  endtask

  // Random requesters that hold valid until granted, checked against a reference arbiter
  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] er;
    int         mptr;
    int         used;
    int         last;
    int         s0;
    int         s1;
    int         i;
    pend = 4'b1100;
    mptr = 2;
    for (int c = 0; c < 200; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!pend[r] && ($urandom_range(0, 9) < 6)) begin
          pend[r] = 1'b1;
          ix[r]   = 5'($urandom_range(0, 3));
          dt[r]   = {$urandom, $urandom};
        end
      end
      bus.req_valid = pend;
      bus.req_idx   = ix;
      bus.req_data  = dt;
      er = '0; s0 = -1; s1 = -1; used = 0; last = -1;
      for (int j = 0; j < 4; j++) begin
        i = (mptr + j) % 4;
        if (!pend[i]) continue;
        if (ZD && ix[i] == 5'd0) begin
          er[i] = 1'b1; last = i;
          continue;
        end
        if (used == 2) continue;
        if (used == 1 && ix[s0] == ix[i]) continue;
        if (used == 0) s0 = i;
        else           s1 = i;
        used++;
        er[i] = 1'b1;
        last  = i;
      end
      if (last >= 0) mptr = (last + 1) % 4;
      @(negedge clock);
      checks++;
      if (bus.req_ready !== er) begin
        errors++; $display("FAIL random_ready: got %b expected %b cycle %0d", bus.req_ready, er, c);
      end
      push_exp(s0, s1);
      pend = pend & ~er;
      @(posedge clock); #1;
    end
    bus.req_valid = '0;
    @(negedge clock);
    push_exp(-1, -1);
    @(posedge clock); #3;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_load();
    test_conflict();
    test_wrap();
    test_idle();
    test_zero_index();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
